mac_tx_sink: RTL and testbench
==============================

# mac_tx_sink

Synthesizable, parametrised capture endpoint for the MAC transmit FIFO interface (ff_tx_*). It sits at the output of the packet-generation path, in place of the MAC, in simulation and hardware bring-up builds. It accepts one Avalon-ST packet and stores its bytes in an internal buffer readable by address. It applies a programmable ready-backpressure pattern, checks SOP/EOP framing and reports length, error and overflow status per packet.

## Interface
- SYMBOLS, 4: bytes per beat; power of two, ≥2.
- DEPTH, 2048: capture buffer size in bytes; multiple of SYMBOLS.
- RDY_PERIOD, 40: backpressure pattern period in cycles.
- RDY_LOW, 20: low cycles at the start of each period; 0 means ready is never throttled.
- MOD_W, log2(SYMBOLS): derived localparam.
- ff_tx_clk  in  1  the single clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high.
- ff_tx_data  in  8*SYMBOLS  beat data; first byte in [8*SYMBOLS-1 -: 8].
- ff_tx_sop / ff_tx_eop / ff_tx_err  in  1  framing and error, qualified by acceptance.
- ff_tx_mod  in  MOD_W  empty byte count; valid on the EOP beat only.
- ff_tx_wren  in  1  source valid.
- ff_tx_rdy  out  1  sink ready; registered.
- pkt_ack  in  1  releases the captured packet and re-arms the sink.
- rd_addr  in  log2(DEPTH)  byte read address.
- rd_data  out  8  byte at rd_addr; 1-cycle latency.
- pkt_done  out  1  one-cycle pulse when a packet completes.
- pkt_len  out  16  accepted bytes in the last packet.
- pkt_err  out  1  ff_tx_err was seen on any beat of the last packet.
- overflow  out  1  pkt_len > DEPTH.
- proto_err  out  1  sticky framing violation.
- pkt_count  out  16  completed packets, wraps at 2^16.
- crc_out  out  32  CRC of the last packet (see Configuration).

## Operation
- A beat is accepted when ff_tx_wren && ff_tx_rdy; this is readyLatency 0.
- States, held in a registered FSM:
  - IDLE: waiting for a packet.
  - RECV: receiving a packet.
  - DONE: holding a completed packet.
- IDLE to RECV: on an accepted SOP beat.
  - Clears the write pointer, running length, pkt_err accumulator and CRC.
  - Stores the beat.
- SOP and EOP on the same accepted beat: the packet completes immediately and the FSM goes from IDLE to DONE.
- An accepted beat in IDLE without SOP is dropped and sets proto_err.
- In RECV:
  - Each accepted beat writes one buffer word and advances the write pointer.
  - Non-EOP beats contribute SYMBOLS bytes.
  - The EOP beat contributes SYMBOLS − ff_tx_mod bytes.
  - ff_tx_mod is ignored on non-EOP beats.
- An accepted SOP beat in RECV sets proto_err and restarts the capture as a new packet; the partial packet is discarded.
- RECV to DONE: on an accepted EOP beat.
- DONE to IDLE: on pkt_ack. pkt_ack outside DONE is ignored.
- Buffer:
  - Organised as DEPTH/SYMBOLS words of 8*SYMBOLS bits.
  - Byte i sits in word i/SYMBOLS, lane i%SYMBOLS, lane 0 being the MSB.
  - Beats beyond DEPTH bytes are not written, but are still counted in pkt_len.
  - Length and word pointer saturate: pkt_len at 0xFFFF, the pointer at DEPTH/SYMBOLS.
- Backpressure counter bp_cnt:
  - Free-runs 0..RDY_PERIOD−1 and wraps.
  - Resets to 0.
- ff_tx_rdy for the next cycle = (next state ≠ DONE) && (next bp_cnt ≥ RDY_LOW).

## Timing
- Reset values:
  - ff_tx_rdy = 0, pkt_done = 0, pkt_len = 0, pkt_err = 0, overflow = 0, proto_err = 0, pkt_count = 0, crc_out = 0, rd_data = 0.
  - State = IDLE, bp_cnt = 0.
- Buffer contents are not cleared by reset.
- Reset mid-packet abandons the packet; no pkt_done is produced.
- pkt_done pulses in the cycle after the EOP beat is accepted.
- In that same cycle:
  - pkt_len, pkt_err, overflow and crc_out are valid.
  - pkt_count has incremented.
  - ff_tx_rdy = 0.
- pkt_len, pkt_err, overflow and crc_out hold their values until the next accepted SOP.
- pkt_ack may arrive in the pkt_done cycle. ff_tx_rdy can then be 1 one cycle later, subject to the pattern.
- rd_data is registered: rd_addr at cycle N appears as rd_data at N+1.
- Reading an address while it is being written returns the old data.

## Configuration
- MAC_TX_SINK_CRC_EN defined:
  - A CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final XOR 0xFFFFFFFF) is computed over the stored bytes of each packet, in byte order, up to SYMBOLS bytes per cycle.
  - crc_out is valid with pkt_done.
  - Bytes beyond DEPTH are excluded.
- Undefined: the CRC logic is absent and crc_out is tied to 0.

## Structure
- Package mac_tx_sink_pkg holds:
  - the state enum (IDLE, RECV, DONE);
  - the CRC polynomial and init constants;
  - a byte-count helper function (mod → valid bytes).
- Sub-module crc32_step: a combinational update over 1..SYMBOLS bytes with a byte-valid mask. It is instantiated only under MAC_TX_SINK_CRC_EN.

## Test plan
- SYMBOLS=4, RDY_LOW=0; 3-beat packet 0x00010203, 0x04050607, 0x0809AAAA with mod=2 on EOP → pkt_len=10, bytes 0..9 = 0x00..0x09, pkt_count=1, pkt_err=0.
- Default pattern: ff_tx_wren held high → ff_tx_rdy is 0 for cycles 0–19 and 1 for cycles 20–39 of each period after reset; only beats where both are high are stored.
- Single beat with SOP+EOP and mod=3, data 0x5A000000 → pkt_len=1, byte 0 = 0x5A; ff_tx_rdy stays 0 until pkt_ack.
- Second SOP mid-packet → proto_err=1; the final capture holds only the second packet. A beat without SOP in IDLE → dropped, proto_err=1.
- DEPTH=16, 6 full beats → pkt_len=24, overflow=1, bytes 0..15 are the first 4 beats.
- CRC build: 9-byte packet "123456789" → crc_out=0xCBF43926. Non-CRC build → crc_out=0.

Source files
------------

// File: rtl/mac_tx_sink_pkg.sv
// Shared types and constants for the mac_tx_sink capture endpoint.
// CRC constants are only consumed when MAC_TX_SINK_CRC_EN is defined.
package mac_tx_sink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [31:0] CRC_POLY   = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;

    // Bytes carried by a beat: all lanes, except on EOP where mod lanes are empty.
    function automatic logic [15:0] valid_bytes(input int unsigned symbols,
                                                input logic [7:0]  mod,
                                                input logic        eop);
        return eop ? 16'(symbols - 32'(mod)) : 16'(symbols);
    endfunction

endpackage

// File: rtl/mac_tx_sink_if.sv
// Avalon-ST ff_tx_* bus between the packet source (master) and the sink (slave).
interface mac_tx_sink_if #(
    parameter int unsigned SYMBOLS = 4
) ();
    localparam int unsigned MOD_W = $clog2(SYMBOLS);

    logic [8*SYMBOLS-1:0] ff_tx_data;
    logic                 ff_tx_sop;
    logic                 ff_tx_eop;
    logic                 ff_tx_err;
    logic [MOD_W-1:0]     ff_tx_mod;
    logic                 ff_tx_wren;
    logic                 ff_tx_rdy;

    modport master (
        output ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_err, ff_tx_mod, ff_tx_wren,
        input  ff_tx_rdy
    );

    modport slave (
        input  ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_err, ff_tx_mod, ff_tx_wren,
        output ff_tx_rdy
    );
endinterface

// File: rtl/mac_tx_sink_crc32_step.sv
// Combinational reflected CRC-32 update over up to SYMBOLS bytes of one beat;
// lane 0 (MSB byte) is consumed first, lanes with bvalid_i low are skipped.
module crc32_step
    import mac_tx_sink_pkg::*;
#(
    parameter int unsigned SYMBOLS = 4
) (
    input  logic [31:0]          crc_i,
    input  logic [8*SYMBOLS-1:0] data_i,
    input  logic [SYMBOLS-1:0]   bvalid_i,
    output logic [31:0]          crc_o
);
    logic [31:0] poly_r;
    logic [31:0] c;

    always_comb begin
        for (int unsigned i = 0; i < 32; i++) begin
            poly_r[i] = CRC_POLY[31-i];
        end
    end

    always_comb begin
        c = crc_i;
        for (int unsigned b = 0; b < SYMBOLS; b++) begin
            if (bvalid_i[b]) begin
                c = c ^ {24'h0, data_i[8*(SYMBOLS-b)-1 -: 8]};
                for (int unsigned k = 0; k < 8; k++) begin
                    c = c[0] ? ((c >> 1) ^ poly_r) : (c >> 1);
                end
            end
        end
        crc_o = c;
    end
endmodule

// File: rtl/mac_tx_sink.sv
// Capture endpoint for the MAC ff_tx_* interface: buffers one packet, throttles ready.
// Define MAC_TX_SINK_CRC_EN to compute a CRC-32 of each captured packet.
module mac_tx_sink
    import mac_tx_sink_pkg::*;
#(
    parameter int unsigned SYMBOLS    = 4,
    parameter int unsigned DEPTH      = 2048,
    parameter int unsigned RDY_PERIOD = 40,
    parameter int unsigned RDY_LOW    = 20
) (
    input  logic                     ff_tx_clk,
    input  logic                     reset,
    mac_tx_sink_if.slave             ff_tx,
    input  logic                     pkt_ack,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [7:0]               rd_data,
    output logic                     pkt_done,
    output logic [15:0]              pkt_len,
    output logic                     pkt_err,
    output logic                     overflow,
    output logic                     proto_err,
    output logic [15:0]              pkt_count,
    output logic [31:0]              crc_out
);
    localparam int unsigned MOD_W = $clog2(SYMBOLS);
    localparam int unsigned WORDS = DEPTH / SYMBOLS;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned WA    = $clog2(WORDS);
    localparam int unsigned PW    = WA + 1;
    localparam int unsigned BPW   = $clog2(RDY_PERIOD + 1);
    localparam logic [PW-1:0]  PTR_MAX = PW'(WORDS);
    localparam logic [BPW-1:0] BP_LAST = BPW'(RDY_PERIOD - 1);

    state_e               state_q, state_d;
    logic [BPW-1:0]       bp_q, bp_d;
    logic                 rdy_q, rdy_d, pat_ok;
    logic [PW-1:0]        wptr_q, wptr_d, ptr_base;
    logic [15:0]          len_q, len_d, len_base, nbytes;
    logic [16:0]          len_sum;
    logic                 err_q, err_d, proto_q, proto_d, done_q, done_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 accept, start, store, we;
    logic [8*SYMBOLS-1:0] mem [WORDS];
    logic [8*SYMBOLS-1:0] rd_word;
    logic [MOD_W-1:0]     rd_lane;
    logic [7:0]           rd_byte, rd_q;

    assign accept = ff_tx.ff_tx_wren && rdy_q;
    assign nbytes = valid_bytes(SYMBOLS, 8'(ff_tx.ff_tx_mod), ff_tx.ff_tx_eop);

    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        len_d    = len_q;
        err_d    = err_q;
        proto_d  = proto_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        start    = 1'b0;
        store    = 1'b0;
        we       = 1'b0;
        ptr_base = wptr_q;
        len_base = len_q;
        len_sum  = '0;
        unique case (state_q)
            IDLE, RECV: begin
                if (accept) begin
                    start = ff_tx.ff_tx_sop;
                    store = ff_tx.ff_tx_sop || (state_q == RECV);
                    if ((state_q == RECV && ff_tx.ff_tx_sop) || (state_q == IDLE && !ff_tx.ff_tx_sop)) begin
                        proto_d = 1'b1;
                    end
                    // A SOP always restarts from an empty capture, discarding any partial packet.
                    if (start) begin
                        ptr_base = '0;
                        len_base = '0;
                    end
                    if (store) begin
                        we      = ptr_base < PTR_MAX;
                        wptr_d  = we ? ptr_base + 1'b1 : ptr_base;
                        len_sum = {1'b0, len_base} + {1'b0, nbytes};
                        len_d   = len_sum[16] ? '1 : len_sum[15:0];
                        err_d   = (start ? 1'b0 : err_q) | ff_tx.ff_tx_err;
                        if (ff_tx.ff_tx_eop) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            cnt_d   = cnt_q + 1'b1;
                        end else begin
                            state_d = RECV;
                        end
                    end
                end
            end
            DONE: begin
                if (pkt_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bp_d = (bp_q == BP_LAST) ? '0 : bp_q + 1'b1;

    generate
        if (RDY_LOW == 0) begin : g_no_throttle
            assign pat_ok = 1'b1;
        end else begin : g_throttle
            assign pat_ok = bp_d >= BPW'(RDY_LOW);
        end
    endgenerate

    assign rdy_d = (state_d != DONE) && pat_ok;

    always_ff @(posedge ff_tx_clk) begin
        if (reset) begin
            state_q <= IDLE;
            bp_q    <= '0;
            rdy_q   <= 1'b0;
            wptr_q  <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            proto_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            bp_q    <= bp_d;
            rdy_q   <= rdy_d;
            wptr_q  <= wptr_d;
            len_q   <= len_d;
            err_q   <= err_d;
            proto_q <= proto_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_byte;
        end
    end

    always_ff @(posedge ff_tx_clk) begin
        if (we && !reset) mem[ptr_base[WA-1:0]] <= ff_tx.ff_tx_data;
    end

    assign rd_word = mem[rd_addr[AW-1:MOD_W]];
    assign rd_lane = rd_addr[MOD_W-1:0];
    assign rd_byte = 8'(rd_word >> (8 * (SYMBOLS - 1 - 32'(rd_lane))));

`ifdef MAC_TX_SINK_CRC_EN
    logic [31:0]        crc_q, crc_d, crc_base, crc_next;
    logic [SYMBOLS-1:0] bvalid;

    always_comb begin
        for (int unsigned b = 0; b < SYMBOLS; b++) begin
            bvalid[b] = 16'(b) < nbytes;
        end
    end

    assign crc_base = start ? CRC_INIT : crc_q;

    crc32_step #(.SYMBOLS(SYMBOLS)) u_crc (
        .crc_i    (crc_base),
        .data_i   (ff_tx.ff_tx_data),
        .bvalid_i (bvalid),
        .crc_o    (crc_next)
    );

    // Only words that land in the buffer feed the CRC, so overflow bytes are excluded.
    assign crc_d = we ? crc_next : crc_base;

    always_ff @(posedge ff_tx_clk) begin
        if (reset) crc_q <= CRC_INIT;
        else       crc_q <= crc_d;
    end

    assign crc_out = crc_q ^ CRC_XOROUT;
`else
    assign crc_out = '0;
`endif

    assign ff_tx.ff_tx_rdy = rdy_q;
    assign rd_data         = rd_q;
    assign pkt_done        = done_q;
    assign pkt_len         = len_q;
    assign pkt_err         = err_q;
    assign overflow        = {1'b0, len_q} > 17'(DEPTH);
    assign proto_err       = proto_q;
    assign pkt_count       = cnt_q;
endmodule

// File: tb/tb_mac_tx_sink.sv
// Directed bench for mac_tx_sink: one small-buffer unthrottled instance for capture
// and framing, one default-parameter instance for the ready pattern.
module tb_mac_tx_sink;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic        err;
        logic [1:0]  mod;
    } beat_t;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    mac_tx_sink_if #(.SYMBOLS(4)) if_m ();
    mac_tx_sink_if #(.SYMBOLS(4)) if_b ();

    logic        ack_m, done_m, err_m, ovf_m, perr_m;
    logic [3:0]  rda_m;
    logic [7:0]  rdd_m;
    logic [15:0] len_m, cnt_m;
    logic [31:0] crc_m;

    logic        ack_b, done_b, err_b, ovf_b, perr_b;
    logic [10:0] rda_b;
    logic [7:0]  rdd_b;
    logic [15:0] len_b, cnt_b;
    logic [31:0] crc_b;

    mac_tx_sink #(.SYMBOLS(4), .DEPTH(16), .RDY_PERIOD(40), .RDY_LOW(0)) dut (
        .ff_tx_clk (clk),    .reset    (reset),  .ff_tx     (if_m),
        .pkt_ack   (ack_m),  .rd_addr  (rda_m),  .rd_data   (rdd_m),
        .pkt_done  (done_m), .pkt_len  (len_m),  .pkt_err   (err_m),
        .overflow  (ovf_m),  .proto_err(perr_m), .pkt_count (cnt_m),
        .crc_out   (crc_m)
    );

    mac_tx_sink #(.SYMBOLS(4), .DEPTH(2048), .RDY_PERIOD(40), .RDY_LOW(20)) dut_bp (
        .ff_tx_clk (clk),    .reset    (reset),  .ff_tx     (if_b),
        .pkt_ack   (ack_b),  .rd_addr  (rda_b),  .rd_data   (rdd_b),
        .pkt_done  (done_b), .pkt_len  (len_b),  .pkt_err   (err_b),
        .overflow  (ovf_b),  .proto_err(perr_b), .pkt_count (cnt_b),
        .crc_out   (crc_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Holds the beat on the bus until a clock edge sees wren && rdy.
    task automatic send_beat(input beat_t b);
        int   waited;
        logic acc;
        waited = 0;
        acc    = 1'b0;
        if_m.ff_tx_data = b.data;
        if_m.ff_tx_sop  = b.sop;
        if_m.ff_tx_eop  = b.eop;
        if_m.ff_tx_err  = b.err;
        if_m.ff_tx_mod  = b.mod;
        if_m.ff_tx_wren = 1'b1;
        while (!acc && waited < 50) begin
            acc = if_m.ff_tx_rdy;
            tick();
            waited++;
        end
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_timeout: got no ready in 50 cycles, expected ready");
        end
    endtask

    task automatic idle_bus();
        if_m.ff_tx_wren = 1'b0;
        if_m.ff_tx_sop  = 1'b0;
        if_m.ff_tx_eop  = 1'b0;
        if_m.ff_tx_err  = 1'b0;
    endtask

    task automatic read_check(input int a, input logic [7:0] exp);
        rda_m = 4'(a);
        tick();
        check($sformatf("byte%0d", a), {24'h0, rdd_m}, {24'h0, exp});
    endtask

    task automatic ack_pkt();
        ack_m = 1'b1;
        tick();
        ack_m = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    initial begin
        beat_t       pk1 [3];
        beat_t       pk4 [4];
        beat_t       pk6 [3];
        rd_vec_t     rv4 [8];
        beat_t       bt;
        logic [31:0] exp_crc;

        pk1[0] = '{32'h0001_0203, 1'b1, 1'b0, 1'b0, 2'd0};
        pk1[1] = '{32'h0405_0607, 1'b0, 1'b0, 1'b0, 2'd0};
        pk1[2] = '{32'h0809_AAAA, 1'b0, 1'b1, 1'b0, 2'd2};

        pk4[0] = '{32'h1111_1111, 1'b1, 1'b0, 1'b0, 2'd0};
        pk4[1] = '{32'h2222_2222, 1'b0, 1'b0, 1'b0, 2'd0};
        pk4[2] = '{32'hA0A1_A2A3, 1'b1, 1'b0, 1'b0, 2'd0};
        pk4[3] = '{32'hB0B1_B2B3, 1'b0, 1'b1, 1'b0, 2'd0};

        rv4[0] = '{4'd0, 8'hA0}; rv4[1] = '{4'd1, 8'hA1};
        rv4[2] = '{4'd2, 8'hA2}; rv4[3] = '{4'd3, 8'hA3};
        rv4[4] = '{4'd4, 8'hB0}; rv4[5] = '{4'd5, 8'hB1};
        rv4[6] = '{4'd6, 8'hB2}; rv4[7] = '{4'd7, 8'hB3};

        pk6[0] = '{32'h3132_3334, 1'b1, 1'b0, 1'b0, 2'd0};
        pk6[1] = '{32'h3536_3738, 1'b0, 1'b0, 1'b0, 2'd0};
        pk6[2] = '{32'h3900_0000, 1'b0, 1'b1, 1'b0, 2'd3};

`ifdef MAC_TX_SINK_CRC_EN
        exp_crc = 32'hCBF4_3926;
`else
        exp_crc = 32'h0;
`endif

        if_m.ff_tx_data = '0; if_m.ff_tx_mod = '0; idle_bus();
        ack_m = 1'b0; rda_m = '0;
        if_b.ff_tx_data = '0; if_b.ff_tx_mod = '0; if_b.ff_tx_sop = 1'b0;
        if_b.ff_tx_eop  = 1'b0; if_b.ff_tx_err = 1'b0; if_b.ff_tx_wren = 1'b1;
        ack_b = 1'b0; rda_b = '0;

        do_reset();
        check("rst_rdy",   {31'h0, if_m.ff_tx_rdy}, 32'h0);
        check("rst_done",  {31'h0, done_m}, 32'h0);
        check("rst_len",   {16'h0, len_m}, 32'h0);
        check("rst_err",   {31'h0, err_m}, 32'h0);
        check("rst_ovf",   {31'h0, ovf_m}, 32'h0);
        check("rst_proto", {31'h0, perr_m}, 32'h0);
        check("rst_cnt",   {16'h0, cnt_m}, 32'h0);
        check("rst_crc",   crc_m, 32'h0);
        check("rst_rd",    {24'h0, rdd_m}, 32'h0);

        // Ready pattern on the throttled instance, wren held high from reset release.
        for (int c = 0; c < 80; c++) begin
            check($sformatf("bp_rdy_c%0d", c), {31'h0, if_b.ff_tx_rdy}, 32'((c % 40) >= 20));
            tick();
        end
        check("bp_proto", {31'h0, perr_b}, 32'h1);
        check("bp_cnt",   {16'h0, cnt_b}, 32'h0);

        // 3-beat packet with mod=2, acked in the pkt_done cycle.
        for (int i = 0; i < 3; i++) send_beat(pk1[i]);
        idle_bus();
        check("p1_done", {31'h0, done_m}, 32'h1);
        check("p1_len",  {16'h0, len_m}, 32'd10);
        check("p1_cnt",  {16'h0, cnt_m}, 32'd1);
        check("p1_err",  {31'h0, err_m}, 32'h0);
        check("p1_ovf",  {31'h0, ovf_m}, 32'h0);
        check("p1_rdy",  {31'h0, if_m.ff_tx_rdy}, 32'h0);
        ack_pkt();
        check("p1_rdy_ack",  {31'h0, if_m.ff_tx_rdy}, 32'h1);
        check("p1_done_end", {31'h0, done_m}, 32'h0);
        for (int a = 0; a < 10; a++) read_check(a, 8'(a));
        check("p1_len_hold", {16'h0, len_m}, 32'd10);

        // Single SOP+EOP beat; ready stays low until ack.
        bt = '{32'h5A00_0000, 1'b1, 1'b1, 1'b0, 2'd3};
        send_beat(bt);
        idle_bus();
        check("p3_done", {31'h0, done_m}, 32'h1);
        check("p3_len",  {16'h0, len_m}, 32'd1);
        check("p3_cnt",  {16'h0, cnt_m}, 32'd2);
        check("p3_rdy",  {31'h0, if_m.ff_tx_rdy}, 32'h0);
        repeat (3) tick();
        check("p3_rdy_hold", {31'h0, if_m.ff_tx_rdy}, 32'h0);
        read_check(0, 8'h5A);
        check("p3_len_hold", {16'h0, len_m}, 32'd1);
        ack_pkt();
        check("p3_rdy_ack", {31'h0, if_m.ff_tx_rdy}, 32'h1);

        // Beat without SOP in IDLE is dropped.
        check("p4a_proto_pre", {31'h0, perr_m}, 32'h0);
        bt = '{32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 2'd0};
        send_beat(bt);
        idle_bus();
        check("p4a_proto", {31'h0, perr_m}, 32'h1);
        check("p4a_done",  {31'h0, done_m}, 32'h0);
        check("p4a_cnt",   {16'h0, cnt_m}, 32'd2);
        check("p4a_len",   {16'h0, len_m}, 32'd1);

        do_reset();
        check("rst2_proto", {31'h0, perr_m}, 32'h0);
        check("rst2_cnt",   {16'h0, cnt_m}, 32'h0);

        // Second SOP mid-packet restarts the capture.
        for (int i = 0; i < 4; i++) send_beat(pk4[i]);
        idle_bus();
        check("p4b_done",  {31'h0, done_m}, 32'h1);
        check("p4b_len",   {16'h0, len_m}, 32'd8);
        check("p4b_cnt",   {16'h0, cnt_m}, 32'd1);
        check("p4b_proto", {31'h0, perr_m}, 32'h1);
        ack_pkt();
        for (int i = 0; i < 8; i++) read_check(int'(rv4[i].addr), rv4[i].exp);

        // Overflow: 6 full beats into a 16-byte buffer, err on beat 2.
        for (int k = 0; k < 6; k++) begin
            bt.data = {8'(16 + 4*k), 8'(17 + 4*k), 8'(18 + 4*k), 8'(19 + 4*k)};
            bt.sop  = (k == 0);
            bt.eop  = (k == 5);
            bt.err  = (k == 2);
            bt.mod  = 2'd0;
            send_beat(bt);
        end
        idle_bus();
        check("p5_done", {31'h0, done_m}, 32'h1);
        check("p5_len",  {16'h0, len_m}, 32'd24);
        check("p5_ovf",  {31'h0, ovf_m}, 32'h1);
        check("p5_err",  {31'h0, err_m}, 32'h1);
        check("p5_cnt",  {16'h0, cnt_m}, 32'd2);
        ack_pkt();
        for (int a = 0; a < 16; a++) read_check(a, 8'(16 + a));

        // "123456789" for the CRC check value.
        for (int i = 0; i < 3; i++) send_beat(pk6[i]);
        idle_bus();
        check("p6_done", {31'h0, done_m}, 32'h1);
        check("p6_len",  {16'h0, len_m}, 32'd9);
        check("p6_err",  {31'h0, err_m}, 32'h0);
        check("p6_ovf",  {31'h0, ovf_m}, 32'h0);
        check("p6_cnt",  {16'h0, cnt_m}, 32'd3);
        check("p6_crc",  crc_m, exp_crc);
        read_check(0, 8'h31);
        read_check(8, 8'h39);
        ack_pkt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
